// File: rtl/axi_lite_channel.sv
// AXI-Lite channel bundle: AW/W/B write path and AR/R read path.
// clk/rstn travel with the bundle for endpoints that want them.
interface axi_lite_channel #(
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned DATA_WIDTH = 64
) (
    input logic clk,
    input logic rstn
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [2:0]            aw_prot;

    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;

    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_resp;

    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]            ar_prot;

    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;

    // Sideband clock/reset are optional for endpoints.
    logic unused_sideband;
    assign unused_sideband = clk ^ rstn;

    modport master (
        output aw_valid, aw_addr, aw_prot,
        output w_valid, w_data, w_strb,
        output b_ready,
        output ar_valid, ar_addr, ar_prot,
        output r_ready,
        input  aw_ready, w_ready, b_valid, b_resp,
        input  ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, aw_prot,
        input  w_valid, w_data, w_strb,
        input  b_ready,
        input  ar_valid, ar_addr, ar_prot,
        input  r_ready,
        output aw_ready, w_ready, b_valid, b_resp,
        output ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axi_lite_ram.sv
// AXI-Lite responder backed by word-addressed byte-enable storage.
// Independent read/write paths, one outstanding transaction each.
module axi_lite_ram #(
    parameter int unsigned WORDS      = 256,
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned DATA_WIDTH = 64
) (
    input logic            clk,
    input logic            rst,
    axi_lite_channel.slave master
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned LSB        = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_W      = $clog2(WORDS);
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(WORDS * STRB_WIDTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Elaboration-time parameter consistency checks.
    if ($bits(master.aw_addr) != ADDR_WIDTH) begin : g_addr_chk
        $fatal(1, "axi_lite_ram: ADDR_WIDTH differs from interface");
    end
    if ($bits(master.w_data) != DATA_WIDTH) begin : g_data_chk
        $fatal(1, "axi_lite_ram: DATA_WIDTH differs from interface");
    end
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_dw_chk
        $fatal(1, "axi_lite_ram: DATA_WIDTH must be 32 or 64");
    end
    if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_words_chk
        $fatal(1, "axi_lite_ram: WORDS must be a power of two >= 2");
    end

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic                  aw_full;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                  b_valid_q;
    logic [1:0]            b_resp_q;
    logic                  r_valid_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;

    logic             aw_hs, w_hs, ar_hs, commit;
    logic             wr_hit, rd_hit;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    logic unused_prot;
    assign unused_prot = ^{master.aw_prot, master.ar_prot};

    assign master.aw_ready = !aw_full;
    assign master.w_ready  = !w_full;
    assign master.ar_ready = !r_valid_q || master.r_ready;
    assign master.b_valid  = b_valid_q;
    assign master.b_resp   = b_resp_q;
    assign master.r_valid  = r_valid_q;
    assign master.r_data   = r_data_q;
    assign master.r_resp   = r_resp_q;

    assign aw_hs  = master.aw_valid && !aw_full;
    assign w_hs   = master.w_valid && !w_full;
    assign ar_hs  = master.ar_valid && master.ar_ready;
    assign commit = aw_full && w_full && (!b_valid_q || master.b_ready);

    assign wr_hit = aw_addr_q < LIMIT;
    assign wr_idx = aw_addr_q[LSB +: IDX_W];
    assign rd_hit = master.ar_addr < LIMIT;
    assign rd_idx = master.ar_addr[LSB +: IDX_W];

    // Write path: hold AW and W independently, commit once both are present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full   <= 1'b0;
            aw_addr_q <= '0;
            w_full    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= master.aw_addr;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= master.w_data;
                w_strb_q <= master.w_strb;
            end
            if (commit) begin
                aw_full   <= 1'b0;
                w_full    <= 1'b0;
                b_valid_q <= 1'b1;
                b_resp_q  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (master.b_ready) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    // Storage is never reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (commit && wr_hit) begin
            for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                if (w_strb_q[b]) begin
                    mem[wr_idx][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    // Read path: a same-edge commit is not visible, so collisions return old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            r_valid_q <= 1'b1;
            r_data_q  <= rd_hit ? mem[rd_idx] : '0;
            r_resp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (master.r_ready) begin
            r_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_lite_ram.sv
// Scoreboard bench for axi_lite_ram: expected responses queued at drive
// time and popped when the DUT presents them.
module tb_axi_lite_ram;
    localparam int unsigned AW = 48;
    localparam int unsigned DW = 64;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct packed {
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic rst;
    logic rstn;
    assign rstn = ~rst;

    axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus (.clk(clk), .rstn(rstn));

    axi_lite_ram #(.WORDS(256), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .master (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [1:0] qb[$];
    rexp_t      qr[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_prot = '0;
        bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb  = '0;
        bus.b_ready  = 1'b0;
        bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_prot = '0;
        bus.r_ready  = 1'b0;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [7:0] s, output logic [1:0] resp, output bit ok);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        bus.aw_valid = 1'b1; bus.aw_addr = a;
        bus.w_valid  = 1'b1; bus.w_data  = d; bus.w_strb = s;
        bus.b_ready  = 1'b1;
        #1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = bus.aw_valid && bus.aw_ready;
            w_hs  = bus.w_valid && bus.w_ready;
            tick(); n++;
            if (aw_hs) begin bus.aw_valid = 1'b0; aw_done = 1; end
            if (w_hs)  begin bus.w_valid  = 1'b0; w_done  = 1; end
        end
        n = 0;
        while (!bus.b_valid && n < 20) begin tick(); n++; end
        ok   = aw_done && w_done && bus.b_valid;
        resp = bus.b_resp;
        tick();
        bus.b_ready = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] data,
                            output logic [1:0] resp, output int lat, output bit ok);
        int n;
        bus.ar_valid = 1'b1; bus.ar_addr = a; bus.r_ready = 1'b1;
        #1;
        n = 0;
        while (!bus.ar_ready && n < 20) begin tick(); n++; end
        tick();
        bus.ar_valid = 1'b0;
        lat = 0;
        while (!bus.r_valid && lat < 20) begin tick(); lat++; end
        ok   = bus.r_valid;
        data = bus.r_data;
        resp = bus.r_resp;
        tick();
        bus.r_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.aw_ready, bus.w_ready, bus.ar_ready} !== 3'b111)
            $display("FAIL reset_ready got=%b exp=111", {bus.aw_ready, bus.w_ready, bus.ar_ready});
        else passed++;
        checks++;
        if ({bus.b_valid, bus.r_valid} !== 2'b00)
            $display("FAIL reset_valid got=%b exp=00", {bus.b_valid, bus.r_valid});
        else passed++;
        checks++;
        if ({bus.b_resp, bus.r_resp, bus.r_data} !== '0)
            $display("FAIL reset_data b_resp=%b r_resp=%b r_data=%h exp=0", bus.b_resp, bus.r_resp, bus.r_data);
        else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic b1, b2;
        logic [1:0] resp;
        logic [DW-1:0] data;
        int lat;
        bit ok;
        rexp_t e;
        bus.aw_valid = 1'b1; bus.aw_addr = 48'h10;
        bus.w_valid  = 1'b1; bus.w_data  = 64'hDEAD_BEEF_CAFE_F00D; bus.w_strb = 8'hFF;
        bus.b_ready  = 1'b0;
        qb.push_back(OKAY);
        tick();
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        b1 = bus.b_valid;
        tick();
        b2 = bus.b_valid;
        checks++;
        if ({b1, b2} !== 2'b01) $display("FAIL basic_b_latency got=%b exp=01", {b1, b2});
        else passed++;
        checks++;
        if (bus.b_resp !== qb[0]) $display("FAIL basic_b_resp got=%b exp=%b", bus.b_resp, qb[0]);
        else passed++;
        void'(qb.pop_front());
        bus.b_ready = 1'b1;
        tick();
        bus.b_ready = 1'b0;
        checks++;
        if (bus.b_valid !== 1'b0) $display("FAIL basic_b_drain got=%b exp=0", bus.b_valid);
        else passed++;
        qr.push_back('{resp: OKAY, data: 64'hDEAD_BEEF_CAFE_F00D});
        axi_read(48'h10, data, resp, lat, ok);
        e = qr.pop_front();
        checks++;
        if (!ok || {resp, data} !== e)
            $display("FAIL basic_read got=%b/%h ok=%0d exp=%b/%h", resp, data, ok, e.resp, e.data);
        else passed++;
        checks++;
        if (lat !== 0) $display("FAIL basic_r_latency got=%0d exp=0", lat);
        else passed++;
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp, bresp;
        logic [DW-1:0] data;
        int lat, bfirst;
        bit ok, wlow;
        rexp_t e;
        axi_write(48'h18, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, resp, ok);
        checks++;
        if (!ok || resp !== OKAY) $display("FAIL wfirst_preload got=%b ok=%0d exp=00", resp, ok);
        else passed++;
        bus.w_valid = 1'b1; bus.w_data = 64'h1122_3344_5566_7788; bus.w_strb = 8'h0F;
        bus.b_ready = 1'b0;
        qb.push_back(OKAY);
        bfirst = -1; wlow = 1; bresp = 2'bxx;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) bus.w_valid = 1'b0;
            if (c <= 4 && bus.w_ready) wlow = 0;
            if (c == 3) begin bus.aw_valid = 1'b1; bus.aw_addr = 48'h18; end
            if (c == 4) bus.aw_valid = 1'b0;
            if (bus.b_valid && bfirst < 0) begin bfirst = c; bresp = bus.b_resp; end
        end
        checks++;
        if (wlow !== 1'b1) $display("FAIL wfirst_w_ready got=high exp=low in cycles 1-4");
        else passed++;
        checks++;
        if (bfirst !== 5) $display("FAIL wfirst_b_cycle got=%0d exp=5", bfirst);
        else passed++;
        checks++;
        if (bresp !== qb[0]) $display("FAIL wfirst_b_resp got=%b exp=%b", bresp, qb[0]);
        else passed++;
        void'(qb.pop_front());
        bus.b_ready = 1'b1;
        tick();
        bus.b_ready = 1'b0;
        qr.push_back('{resp: OKAY, data: 64'hAAAA_AAAA_5566_7788});
        axi_read(48'h18, data, resp, lat, ok);
        e = qr.pop_front();
        checks++;
        if (!ok || {resp, data} !== e)
            $display("FAIL wfirst_read got=%b/%h exp=%b/%h", resp, data, e.resp, e.data);
        else passed++;
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp;
        logic [DW-1:0] data;
        int lat;
        bit ok;
        rexp_t e;
        axi_write(48'h0, 64'h0123_4567_89AB_CDEF, 8'hFF, resp, ok);
        axi_write(48'h7F8, 64'hFEED_FACE_0BAD_F00D, 8'hFF, resp, ok);
        qb.push_back(OKAY);
        checks++;
        if (!ok || resp !== qb[0]) $display("FAIL range_last_word_wr got=%b exp=%b", resp, qb[0]);
        else passed++;
        void'(qb.pop_front());
        qb.push_back(SLVERR);
        axi_write(48'h800, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp, ok);
        checks++;
        if (!ok || resp !== qb[0]) $display("FAIL range_oor_wr got=%b exp=%b", resp, qb[0]);
        else passed++;
        void'(qb.pop_front());
        qr.push_back('{resp: SLVERR, data: 64'h0});
        qr.push_back('{resp: OKAY, data: 64'h0123_4567_89AB_CDEF});
        qr.push_back('{resp: OKAY, data: 64'hFEED_FACE_0BAD_F00D});
        axi_read(48'h800, data, resp, lat, ok);
        e = qr.pop_front();
        checks++;
        if (!ok || {resp, data} !== e)
            $display("FAIL range_oor_rd got=%b/%h exp=%b/%h", resp, data, e.resp, e.data);
        else passed++;
        axi_read(48'h0, data, resp, lat, ok);
        e = qr.pop_front();
        checks++;
        if (!ok || {resp, data} !== e)
            $display("FAIL range_word0_intact got=%b/%h exp=%b/%h", resp, data, e.resp, e.data);
        else passed++;
        axi_read(48'h7FF, data, resp, lat, ok);
        e = qr.pop_front();
        checks++;
        if (!ok || {resp, data} !== e)
            $display("FAIL range_unaligned_last got=%b/%h exp=%b/%h", resp, data, e.resp, e.data);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [1:0] resp;
        logic [DW-1:0] data;
        int lat;
        bit ok;
        rexp_t e;
        axi_write(48'h28, 64'h5555_5555_5555_5555, 8'hFF, resp, ok);
        bus.b_ready = 1'b0;
        bus.aw_valid = 1'b1; bus.aw_addr = 48'h900;
        bus.w_valid  = 1'b1; bus.w_data  = 64'h1; bus.w_strb = 8'hFF;
        qb.push_back(SLVERR);
        tick();
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        tick();
        bus.aw_valid = 1'b1; bus.aw_addr = 48'h28;
        bus.w_valid  = 1'b1; bus.w_data  = 64'h0F0F_0F0F_0F0F_0F0F; bus.w_strb = 8'hFF;
        qb.push_back(OKAY);
        tick();
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        checks++;
        if ({bus.aw_ready, bus.w_ready} !== 2'b00)
            $display("FAIL bp_ready_drop got=%b exp=00", {bus.aw_ready, bus.w_ready});
        else passed++;
        qr.push_back('{resp: OKAY, data: 64'h5555_5555_5555_5555});
        axi_read(48'h28, data, resp, lat, ok);
        e = qr.pop_front();
        checks++;
        if (!ok || {resp, data} !== e)
            $display("FAIL bp_old_read got=%b/%h exp=%b/%h", resp, data, e.resp, e.data);
        else passed++;
        checks++;
        if ({bus.b_valid, bus.b_resp} !== {1'b1, qb[0]})
            $display("FAIL bp_a_held got=%b/%b exp=1/%b", bus.b_valid, bus.b_resp, qb[0]);
        else passed++;
        void'(qb.pop_front());
        bus.b_ready = 1'b1;
        tick();
        bus.b_ready = 1'b0;
        checks++;
        if ({bus.b_valid, bus.b_resp, bus.aw_ready, bus.w_ready} !== {1'b1, qb[0], 2'b11})
            $display("FAIL bp_b_commit got=%b/%b/%b exp=1/%b/11", bus.b_valid, bus.b_resp,
                     {bus.aw_ready, bus.w_ready}, qb[0]);
        else passed++;
        void'(qb.pop_front());
        bus.b_ready = 1'b1;
        tick();
        bus.b_ready = 1'b0;
        checks++;
        if (bus.b_valid !== 1'b0) $display("FAIL bp_b_drain got=%b exp=0", bus.b_valid);
        else passed++;
        qr.push_back('{resp: OKAY, data: 64'h0F0F_0F0F_0F0F_0F0F});
        axi_read(48'h28, data, resp, lat, ok);
        e = qr.pop_front();
        checks++;
        if (!ok || {resp, data} !== e)
            $display("FAIL bp_new_read got=%b/%h exp=%b/%h", resp, data, e.resp, e.data);
        else passed++;
    endtask

    task automatic test_back_to_back_reads();
        logic [AW-1:0] addrs [3];
        logic [1:0] resp;
        logic [DW-1:0] data;
        int lat;
        bit ok, bseen;
        rexp_t e;
        addrs[0] = 48'h0; addrs[1] = 48'h8; addrs[2] = 48'h10;
        axi_write(48'h8, 64'h8888_0000_8888_0000, 8'hFF, resp, ok);
        bus.r_ready = 1'b1; bus.b_ready = 1'b1;
        bus.aw_valid = 1'b1; bus.aw_addr = 48'h8;
        bus.w_valid  = 1'b1; bus.w_data  = 64'h9999_1111_9999_1111; bus.w_strb = 8'hFF;
        qb.push_back(OKAY);
        qr.push_back('{resp: OKAY, data: 64'h0123_4567_89AB_CDEF});
        qr.push_back('{resp: OKAY, data: 64'h8888_0000_8888_0000});
        qr.push_back('{resp: OKAY, data: 64'hDEAD_BEEF_CAFE_F00D});
        bseen = 0;
        for (int c = 0; c <= 3; c++) begin
            if (c < 3) begin bus.ar_valid = 1'b1; bus.ar_addr = addrs[c]; end
            else bus.ar_valid = 1'b0;
            tick();
            if (c == 0) begin bus.aw_valid = 1'b0; bus.w_valid = 1'b0; end
            if (bus.b_valid && !bseen) begin
                bseen = 1;
                checks++;
                if (bus.b_resp !== qb[0]) $display("FAIL tput_b_resp got=%b exp=%b", bus.b_resp, qb[0]);
                else passed++;
                void'(qb.pop_front());
            end
            if (c < 3) begin
                e = qr.pop_front();
                checks++;
                if ({bus.r_valid, bus.r_resp, bus.r_data} !== {1'b1, e})
                    $display("FAIL tput_read%0d got=%b/%b/%h exp=1/%b/%h", c, bus.r_valid,
                             bus.r_resp, bus.r_data, e.resp, e.data);
                else passed++;
            end
        end
        checks++;
        if ({bus.r_valid, bseen} !== 2'b01)
            $display("FAIL tput_tail r_valid=%b b_seen=%0d exp=0/1", bus.r_valid, bseen);
        else passed++;
        bus.r_ready = 1'b0; bus.b_ready = 1'b0;
        qr.push_back('{resp: OKAY, data: 64'h9999_1111_9999_1111});
        axi_read(48'h8, data, resp, lat, ok);
        e = qr.pop_front();
        checks++;
        if (!ok || {resp, data} !== e)
            $display("FAIL tput_new_read got=%b/%h exp=%b/%h", resp, data, e.resp, e.data);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        logic [1:0] resp;
        logic [DW-1:0] data;
        int lat, n;
        bit ok, stray;
        rexp_t e;
        axi_write(48'h30, 64'h3030_3030_3030_3030, 8'hFF, resp, ok);
        bus.ar_valid = 1'b1; bus.ar_addr = 48'h10; bus.r_ready = 1'b0;
        bus.aw_valid = 1'b1; bus.aw_addr = 48'h30;
        tick();
        bus.ar_valid = 1'b0; bus.aw_valid = 1'b0;
        checks++;
        if ({bus.aw_ready, bus.w_ready, bus.r_valid} !== 3'b011)
            $display("FAIL rstmid_setup got=%b exp=011", {bus.aw_ready, bus.w_ready, bus.r_valid});
        else passed++;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid, bus.r_valid} !== 5'b11100)
            $display("FAIL rstmid_flags got=%b exp=11100",
                     {bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid, bus.r_valid});
        else passed++;
        checks++;
        if ({bus.b_resp, bus.r_resp, bus.r_data} !== '0)
            $display("FAIL rstmid_data got=%b/%b/%h exp=0", bus.b_resp, bus.r_resp, bus.r_data);
        else passed++;
        tick(); tick();
        rst = 1'b0;
        bus.w_valid = 1'b1; bus.w_data = 64'h3838_3838_3838_3838; bus.w_strb = 8'hFF;
        bus.b_ready = 1'b1;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            bus.w_valid = 1'b0;
            if (bus.b_valid || bus.r_valid) stray = 1;
        end
        checks++;
        if (stray !== 1'b0) $display("FAIL rstmid_no_stray got=1 exp=0");
        else passed++;
        bus.aw_valid = 1'b1; bus.aw_addr = 48'h38;
        qb.push_back(OKAY);
        tick();
        bus.aw_valid = 1'b0;
        n = 0;
        while (!bus.b_valid && n < 20) begin tick(); n++; end
        checks++;
        if (!bus.b_valid || bus.b_resp !== qb[0])
            $display("FAIL rstmid_pair got=%b/%b exp=1/%b", bus.b_valid, bus.b_resp, qb[0]);
        else passed++;
        void'(qb.pop_front());
        tick();
        bus.b_ready = 1'b0;
        qr.push_back('{resp: OKAY, data: 64'h3030_3030_3030_3030});
        qr.push_back('{resp: OKAY, data: 64'h3838_3838_3838_3838});
        qr.push_back('{resp: OKAY, data: 64'hDEAD_BEEF_CAFE_F00D});
        axi_read(48'h30, data, resp, lat, ok);
        e = qr.pop_front();
        checks++;
        if (!ok || {resp, data} !== e)
            $display("FAIL rstmid_held_dropped got=%b/%h exp=%b/%h", resp, data, e.resp, e.data);
        else passed++;
        axi_read(48'h38, data, resp, lat, ok);
        e = qr.pop_front();
        checks++;
        if (!ok || {resp, data} !== e)
            $display("FAIL rstmid_new_write got=%b/%h exp=%b/%h", resp, data, e.resp, e.data);
        else passed++;
        axi_read(48'h10, data, resp, lat, ok);
        e = qr.pop_front();
        checks++;
        if (!ok || {resp, data} !== e)
            $display("FAIL rstmid_storage_kept got=%b/%h exp=%b/%h", resp, data, e.resp, e.data);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_back_to_back_reads();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
